// File: rtl/hms_timekeeper.sv
// hms_timekeeper
// Hour:minute:second timekeeper with NUM_ALARM alarm channels, field-wise
// setup and an alarm ringing state machine. All state lives in the clk
// domain. Time only advances on the single-cycle i_tick enable.
//
// Optional feature: define HMS_SNOOZE_EN to add the i_snooze input and the
// SNOOZE ring state. Without it the block has no snooze port or state.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active-high
//   i_tick       1 Hz strobe, one clk wide
//   i_mode       00 RUN, 01 SET_TIME, 10 SET_ALARM, 11 RUN
//   i_pos        field to edit: 0 sec, 1 min, 2 hour, 3 none
//   i_alarm_sel  alarm channel to edit/display
//   i_inc        single-cycle increment pulse
//   i_alarm_en   per-channel arm
//   i_alarm_ack  single-cycle pulse, stops ringing
//   i_snooze     (HMS_SNOOZE_EN only) single-cycle pulse, snoozes a ring
//   o_sec/o_min/o_hour  registered display (time, or selected alarm)
//   o_ring       alarm sounding
//   o_ring_ch    channels that caused the current ring
//   o_day_pulse  one-cycle pulse on the HOUR_MAX:59:59 -> 0:00:00 wrap
//
// Ring FSM states
//   state  | meaning
//   IDLE   | silent, waiting for an alarm match
//   RING   | sounding, counting ticks up to ALARM_LEN_SEC
//   SNOOZE | silent but channels held, counting ticks up to SNOOZE_SEC

module hms_timekeeper #(
  parameter int NUM_ALARM     = 2,
  parameter int HOUR_MAX      = 23,
  parameter int ALARM_LEN_SEC = 60,
  parameter int SNOOZE_SEC    = 300,
  localparam int AW = (NUM_ALARM > 1) ? $clog2(NUM_ALARM) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_tick,
  input  logic [1:0]           i_mode,
  input  logic [1:0]           i_pos,
  input  logic [AW-1:0]        i_alarm_sel,
  input  logic                 i_inc,
  input  logic [NUM_ALARM-1:0] i_alarm_en,
  input  logic                 i_alarm_ack,
`ifdef HMS_SNOOZE_EN
  input  logic                 i_snooze,
`endif
  output logic [5:0]           o_sec,
  output logic [5:0]           o_min,
  output logic [4:0]           o_hour,
  output logic                 o_ring,
  output logic [NUM_ALARM-1:0] o_ring_ch,
  output logic                 o_day_pulse
);

  // One duration counter serves both ring and snooze timing.
  localparam int DUR_MAX = (ALARM_LEN_SEC > SNOOZE_SEC) ? ALARM_LEN_SEC : SNOOZE_SEC;
  localparam int DW      = $clog2(DUR_MAX + 1);

  localparam logic [1:0] MODE_SET_TIME  = 2'b01;
  localparam logic [1:0] MODE_SET_ALARM = 2'b10;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RING   = 2'd1;
`ifdef HMS_SNOOZE_EN
  localparam logic [1:0] ST_SNOOZE = 2'd2;
`endif

  function automatic logic [5:0] f_inc60(input logic [5:0] v);
    return (v >= 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] f_inc_hr(input logic [4:0] v);
    return (v >= 5'(HOUR_MAX)) ? 5'd0 : v + 5'd1;
  endfunction

  // Time and alarm storage
  logic [5:0]           r_sec, r_min;
  logic [4:0]           r_hour;
  logic [5:0]           r_al_sec  [NUM_ALARM];
  logic [5:0]           r_al_min  [NUM_ALARM];
  logic [4:0]           r_al_hour [NUM_ALARM];
  logic [5:0]           r_disp_sec, r_disp_min;
  logic [4:0]           r_disp_hour;
  logic                 r_upd;
  logic                 r_day;

  logic [5:0]           w_sec_n, w_min_n;
  logic [4:0]           w_hour_n;
  logic [5:0]           w_al_sec_n  [NUM_ALARM];
  logic [5:0]           w_al_min_n  [NUM_ALARM];
  logic [4:0]           w_al_hour_n [NUM_ALARM];
  logic [5:0]           w_disp_sec, w_disp_min;
  logic [4:0]           w_disp_hour;
  logic                 w_run_tick;
  logic                 w_wrap;
  logic                 w_al_edit;
  logic [NUM_ALARM-1:0] w_match;

  // Ring FSM
  logic [1:0]           r_state, w_state_n;
  logic [NUM_ALARM-1:0] r_ch, w_ch_n;
  logic [DW-1:0]        r_dur, w_dur_n;

  assign w_run_tick = i_tick && (i_mode != MODE_SET_TIME);
  assign w_al_edit  = i_inc && (i_mode == MODE_SET_ALARM);

  // Time next-value: run ticks carry through all fields, setup edits wrap
  // a single field without carry.
  always_comb begin
    w_sec_n  = r_sec;
    w_min_n  = r_min;
    w_hour_n = r_hour;
    w_wrap   = 1'b0;
    if (w_run_tick) begin
      w_sec_n = f_inc60(r_sec);
      if (r_sec == 6'd59) begin
        w_min_n = f_inc60(r_min);
        if (r_min == 6'd59) begin
          w_hour_n = f_inc_hr(r_hour);
          w_wrap   = (r_hour == 5'(HOUR_MAX));
        end
      end
    end else if (i_inc && (i_mode == MODE_SET_TIME)) begin
      case (i_pos)
        2'd0:    w_sec_n  = f_inc60(r_sec);
        2'd1:    w_min_n  = f_inc60(r_min);
        2'd2:    w_hour_n = f_inc_hr(r_hour);
        default: ;
      endcase
    end
  end

  // Alarm edits. An out-of-range i_alarm_sel matches no channel, so the
  // increment is dropped.
  always_comb begin
    for (int k = 0; k < NUM_ALARM; k++) begin
      w_al_sec_n[k]  = r_al_sec[k];
      w_al_min_n[k]  = r_al_min[k];
      w_al_hour_n[k] = r_al_hour[k];
      if (w_al_edit && (i_alarm_sel == AW'(k))) begin
        case (i_pos)
          2'd0:    w_al_sec_n[k]  = f_inc60(r_al_sec[k]);
          2'd1:    w_al_min_n[k]  = f_inc60(r_al_min[k]);
          2'd2:    w_al_hour_n[k] = f_inc_hr(r_al_hour[k]);
          default: ;
        endcase
      end
    end
  end

  // Display is loaded from next values so a tick in cycle N shows in N+1.
  always_comb begin
    w_disp_sec  = w_sec_n;
    w_disp_min  = w_min_n;
    w_disp_hour = w_hour_n;
    if (i_mode == MODE_SET_ALARM) begin
      w_disp_sec  = 6'd0;
      w_disp_min  = 6'd0;
      w_disp_hour = 5'd0;
      for (int k = 0; k < NUM_ALARM; k++) begin
        if (i_alarm_sel == AW'(k)) begin
          w_disp_sec  = w_al_sec_n[k];
          w_disp_min  = w_al_min_n[k];
          w_disp_hour = w_al_hour_n[k];
        end
      end
    end
  end

  // Matching is gated by r_upd so only tick-driven time changes can ring.
  always_comb begin
    for (int k = 0; k < NUM_ALARM; k++) begin
      w_match[k] = r_upd && i_alarm_en[k] &&
                   (r_sec == r_al_sec[k]) && (r_min == r_al_min[k]) &&
                   (r_hour == r_al_hour[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sec       <= '0;
      r_min       <= '0;
      r_hour      <= '0;
      r_disp_sec  <= '0;
      r_disp_min  <= '0;
      r_disp_hour <= '0;
      r_upd       <= 1'b0;
      r_day       <= 1'b0;
      for (int k = 0; k < NUM_ALARM; k++) begin
        r_al_sec[k]  <= '0;
        r_al_min[k]  <= '0;
        r_al_hour[k] <= '0;
      end
    end else begin
      r_sec       <= w_sec_n;
      r_min       <= w_min_n;
      r_hour      <= w_hour_n;
      r_disp_sec  <= w_disp_sec;
      r_disp_min  <= w_disp_min;
      r_disp_hour <= w_disp_hour;
      r_upd       <= w_run_tick;
      r_day       <= w_wrap;
      for (int k = 0; k < NUM_ALARM; k++) begin
        r_al_sec[k]  <= w_al_sec_n[k];
        r_al_min[k]  <= w_al_min_n[k];
        r_al_hour[k] <= w_al_hour_n[k];
      end
    end
  end

  // Ring FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ch    <= '0;
      r_dur   <= '0;
    end else begin
      r_state <= w_state_n;
      r_ch    <= w_ch_n;
      r_dur   <= w_dur_n;
    end
  end

  // Ring FSM: next state. Priority in RING is ack, new match, loss of all
  // enables, snooze, then duration expiry; ack always swallows a match.
  always_comb begin
    w_state_n = r_state;
    w_ch_n    = r_ch;
    w_dur_n   = r_dur;
    case (r_state)
      ST_IDLE: begin
        if ((|w_match) && !i_alarm_ack) begin
          w_state_n = ST_RING;
          w_ch_n    = w_match;
          w_dur_n   = '0;
        end
      end
      ST_RING: begin
        if (i_alarm_ack) begin
          w_state_n = ST_IDLE;
          w_ch_n    = '0;
          w_dur_n   = '0;
        end else if (|w_match) begin
          w_ch_n  = r_ch | w_match;
          w_dur_n = '0;
        end else if ((r_ch & i_alarm_en) == '0) begin
          w_state_n = ST_IDLE;
          w_ch_n    = '0;
          w_dur_n   = '0;
`ifdef HMS_SNOOZE_EN
        end else if (i_snooze) begin
          w_state_n = ST_SNOOZE;
          w_dur_n   = '0;
`endif
        end else if (i_tick) begin
          if (r_dur == DW'(ALARM_LEN_SEC - 1)) begin
            w_state_n = ST_IDLE;
            w_ch_n    = '0;
            w_dur_n   = '0;
          end else begin
            w_dur_n = r_dur + 1'b1;
          end
        end
      end
`ifdef HMS_SNOOZE_EN
      ST_SNOOZE: begin
        if (i_alarm_ack) begin
          w_state_n = ST_IDLE;
          w_ch_n    = '0;
          w_dur_n   = '0;
        end else if (|w_match) begin
          w_state_n = ST_RING;
          w_ch_n    = r_ch | w_match;
          w_dur_n   = '0;
        end else if (i_tick) begin
          if (r_dur == DW'(SNOOZE_SEC - 1)) begin
            w_state_n = ST_RING;
            w_dur_n   = '0;
          end else begin
            w_dur_n = r_dur + 1'b1;
          end
        end
      end
`endif
      default: begin
        w_state_n = ST_IDLE;
        w_ch_n    = '0;
        w_dur_n   = '0;
      end
    endcase
  end

  // Ring FSM: outputs
  always_comb begin
    o_ring    = (r_state == ST_RING);
    o_ring_ch = r_ch;
  end

  assign o_sec       = r_disp_sec;
  assign o_min       = r_disp_min;
  assign o_hour      = r_disp_hour;
  assign o_day_pulse = r_day;

endmodule

// File: tb/tb_hms_timekeeper.sv
module tb_hms_timekeeper;

  localparam int NUM = 2;
  localparam int HM  = 23;
  localparam int LEN = 60;
  localparam int SN  = 3;
  localparam int AW  = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int HN  = HM + 1;
  localparam int DAY = HN * 3600;

  logic           clk = 1'b0;
  logic           rst;
  logic           i_tick, i_inc, i_alarm_ack;
  logic [1:0]     i_mode, i_pos;
  logic [AW-1:0]  i_alarm_sel;
  logic [NUM-1:0] i_alarm_en;
`ifdef HMS_SNOOZE_EN
  logic           i_snooze;
`endif
  logic [5:0]     o_sec, o_min, u2_sec, u2_min;
  logic [4:0]     o_hour, u2_hour;
  logic           o_ring, o_day_pulse, u2_ring, u2_day;
  logic [NUM-1:0] o_ring_ch, u2_ring_ch;

  always #5 clk = ~clk;

  hms_timekeeper #(.NUM_ALARM(NUM), .HOUR_MAX(HM), .ALARM_LEN_SEC(LEN), .SNOOZE_SEC(SN)) u_dut (
    .clk(clk), .rst(rst), .i_tick(i_tick), .i_mode(i_mode), .i_pos(i_pos),
    .i_alarm_sel(i_alarm_sel), .i_inc(i_inc), .i_alarm_en(i_alarm_en), .i_alarm_ack(i_alarm_ack),
`ifdef HMS_SNOOZE_EN
    .i_snooze(i_snooze),
`endif
    .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour), .o_ring(o_ring),
    .o_ring_ch(o_ring_ch), .o_day_pulse(o_day_pulse));

  // 12 h build, only checked during the rollover step
  hms_timekeeper #(.NUM_ALARM(NUM), .HOUR_MAX(11), .ALARM_LEN_SEC(LEN), .SNOOZE_SEC(SN)) u_dut12 (
    .clk(clk), .rst(rst), .i_tick(i_tick), .i_mode(i_mode), .i_pos(i_pos),
    .i_alarm_sel(i_alarm_sel), .i_inc(i_inc), .i_alarm_en(i_alarm_en), .i_alarm_ack(i_alarm_ack),
`ifdef HMS_SNOOZE_EN
    .i_snooze(i_snooze),
`endif
    .o_sec(u2_sec), .o_min(u2_min), .o_hour(u2_hour), .o_ring(u2_ring),
    .o_ring_ch(u2_ring_ch), .o_day_pulse(u2_day));

  int n_chk = 0;
  int n_err = 0;

  // Reference model: time and alarms as seconds-of-day, ring as a mode flag
  int             m_t;
  int             m_al [NUM];
  bit             m_upd, m_day;
  int             m_state;   // 0 silent, 1 ringing, 2 snoozed
  logic [NUM-1:0] m_ch;
  int             m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bump(input int t, input int pos, input int hmax);
    int h, m, s;
    h = t / 3600; m = (t / 60) % 60; s = t % 60;
    case (pos)
      0: s = (s + 1) % 60;
      1: m = (m + 1) % 60;
      2: h = (h + 1) % (hmax + 1);
      default: ;
    endcase
    return h * 3600 + m * 60 + s;
  endfunction

  task automatic model_reset();
    m_t = 0; m_upd = 0; m_day = 0; m_state = 0; m_ch = '0; m_cnt = 0;
    for (int k = 0; k < NUM; k++) m_al[k] = 0;
  endtask

  task automatic model_edge();
    logic [NUM-1:0] mt;
    bit snz;
    if (rst) begin
      model_reset();
      return;
    end
    snz = 1'b0;
`ifdef HMS_SNOOZE_EN
    snz = i_snooze;
`endif
    mt = '0;
    if (m_upd)
      for (int k = 0; k < NUM; k++)
        if (i_alarm_en[k] && m_al[k] == m_t) mt[k] = 1'b1;
    case (m_state)
      0: if (mt != 0 && !i_alarm_ack) begin m_state = 1; m_ch = mt; m_cnt = 0; end
      1: begin
        if (i_alarm_ack) begin m_state = 0; m_ch = '0; end
        else if (mt != 0) begin m_ch = m_ch | mt; m_cnt = 0; end
        else if ((m_ch & i_alarm_en) == 0) begin m_state = 0; m_ch = '0; end
        else if (snz) begin m_state = 2; m_cnt = 0; end
        else if (i_tick) begin
          m_cnt++;
          if (m_cnt >= LEN) begin m_state = 0; m_ch = '0; end
        end
      end
      default: begin
        if (i_alarm_ack) begin m_state = 0; m_ch = '0; end
        else if (mt != 0) begin m_state = 1; m_ch = m_ch | mt; m_cnt = 0; end
        else if (i_tick) begin
          m_cnt++;
          if (m_cnt >= SN) begin m_state = 1; m_cnt = 0; end
        end
      end
    endcase
    if (i_inc && i_pos != 2'd3 && i_mode == 2'b10 && int'(i_alarm_sel) < NUM)
      m_al[int'(i_alarm_sel)] = bump(m_al[int'(i_alarm_sel)], int'(i_pos), HM);
    if (i_tick && i_mode != 2'b01) begin
      m_t = (m_t + 1) % DAY; m_upd = 1; m_day = (m_t == 0);
    end else begin
      m_upd = 0; m_day = 0;
      if (i_inc && i_pos != 2'd3 && i_mode == 2'b01) m_t = bump(m_t, int'(i_pos), HM);
    end
  endtask

  task automatic check_all();
    int v;
    v = m_t;
    if (i_mode == 2'b10) v = (int'(i_alarm_sel) < NUM) ? m_al[int'(i_alarm_sel)] : 0;
    chk("sec", 32'(o_sec), 32'(v % 60));
    chk("min", 32'(o_min), 32'(v / 60 % 60));
    chk("hour", 32'(o_hour), 32'(v / 3600));
    chk("ring", 32'(o_ring), 32'(m_state == 1));
    chk("ring_ch", 32'(o_ring_ch), (m_state != 0) ? 32'(m_ch) : 32'd0);
    chk("day_pulse", 32'(o_day_pulse), 32'(m_day));
  endtask

  // One clock: inputs already driven, advance model at the edge, check,
  // then drop the single-cycle pulses.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    i_tick = 0; i_inc = 0; i_alarm_ack = 0;
`ifdef HMS_SNOOZE_EN
    i_snooze = 0;
`endif
  endtask

  task automatic edit_field(input int pos, input int n);
    i_pos = 2'(pos);
    repeat (n) begin i_inc = 1; cycle(); end
  endtask

  task automatic set_time(input int h, input int m, input int s);
    i_mode = 2'b01;
    edit_field(2, (h - m_t / 3600 + HN) % HN);
    edit_field(1, (m - m_t / 60 % 60 + 60) % 60);
    edit_field(0, (s - m_t % 60 + 60) % 60);
  endtask

  task automatic set_alarm(input int k, input int h, input int m, input int s);
    i_mode = 2'b10; i_alarm_sel = AW'(k);
    edit_field(2, (h - m_al[k] / 3600 + HN) % HN);
    edit_field(1, (m - m_al[k] / 60 % 60 + 60) % 60);
    edit_field(0, (s - m_al[k] % 60 + 60) % 60);
  endtask

  task automatic tick_gap();
    i_tick = 1; cycle(); cycle();
  endtask

  task automatic ring_up();
    set_time(0, 1, 4);
    i_mode = 2'b00;
    i_tick = 1; cycle();
    chk("ring_lat1", 32'(o_ring), 32'd0);
    cycle();
    chk("ring_lat2", 32'(o_ring), 32'd1);
    chk("ring_ch_lat2", 32'(o_ring_ch), 32'b10);
  endtask

  initial begin
    int r, t2;
    rst = 1; i_tick = 0; i_inc = 0; i_alarm_ack = 0; i_mode = 2'b00; i_pos = 2'd3;
    i_alarm_sel = '0; i_alarm_en = '0;
`ifdef HMS_SNOOZE_EN
    i_snooze = 0;
`endif
    model_reset();
    repeat (3) cycle();
    #1 rst = 0;
    cycle();

    // Rollover, both 24 h and 12 h builds
    set_time(23, 59, 58);
    i_mode = 2'b00;
    i_tick = 1; cycle();
    chk("roll_hour", 32'(o_hour), 32'd23);
    chk("roll_sec", 32'(o_sec), 32'd59);
    chk("roll12_hour", 32'(u2_hour), 32'd11);
    chk("roll12_sec", 32'(u2_sec), 32'd59);
    chk("roll12_ring", 32'(u2_ring), 32'd0);
    chk("roll12_ring_ch", 32'(u2_ring_ch), 32'd0);
    i_tick = 1; cycle();
    chk("wrap_hour", 32'(o_hour), 32'd0);
    chk("wrap_day", 32'(o_day_pulse), 32'd1);
    chk("wrap12_hms", {u2_hour, u2_min, u2_sec}, 32'd0);
    chk("wrap12_day", 32'(u2_day), 32'd1);
    cycle();
    chk("day_clear", 32'(o_day_pulse), 32'd0);
    chk("day12_clear", 32'(u2_day), 32'd0);

    // Setup wrap, ignored position, frozen time in SET_TIME
    set_time(5, 59, 0);
    i_pos = 2'd1; i_inc = 1; cycle();
    chk("minwrap_min", 32'(o_min), 32'd0);
    chk("minwrap_hour", 32'(o_hour), 32'd5);
    i_pos = 2'd3; i_inc = 1; cycle();
    chk("pos3_hms", {o_hour, o_min, o_sec}, {15'd0, 5'd5, 6'd0, 6'd0});
    repeat (10) tick_gap();
    chk("frozen_sec", 32'(o_sec), 32'd0);

    // Alarm ring and duration
    i_alarm_en = 2'b10;
    set_alarm(1, 0, 1, 5);
    ring_up();
    repeat (59) tick_gap();
    chk("ring_59", 32'(o_ring), 32'd1);
    i_tick = 1; cycle();
    chk("ring_60", 32'(o_ring), 32'd0);

    // Ack while ringing
    ring_up();
    cycle();
    i_alarm_ack = 1; cycle();
    chk("ack_ring", 32'(o_ring), 32'd0);

    // Ack coincident with another channel's match
    set_alarm(0, 0, 1, 10);
    i_alarm_en = 2'b11;
    ring_up();
    repeat (4) tick_gap();
    i_tick = 1; cycle();
    i_alarm_ack = 1; cycle();
    chk("ackwin_ring", 32'(o_ring), 32'd0);
    cycle(); cycle();
    chk("ackwin_stay", 32'(o_ring_ch), 32'd0);

    // Asynchronous reset mid-ring
    i_alarm_en = 2'b10;
    set_alarm(1, 0, 1, 5);
    ring_up();
    #2 rst = 1;
    #1 model_reset();
    chk("arst_ring", 32'(o_ring), 32'd0);
    chk("arst_ring_ch", 32'(o_ring_ch), 32'd0);
    chk("arst_hms", {o_hour, o_min, o_sec}, 32'd0);
    chk("arst_day", 32'(o_day_pulse), 32'd0);
    cycle();
    rst = 0;
    i_mode = 2'b00; i_alarm_en = 2'b11;
    tick_gap(); cycle();
    chk("rst_noring", 32'(o_ring), 32'd0);

    // Disable the ringing channel
    i_alarm_en = 2'b10;
    set_alarm(1, 0, 1, 5);
    ring_up();
    cycle();
    i_alarm_en = 2'b00; cycle();
    chk("dis_ring", 32'(o_ring), 32'd0);

    // Editing time onto the alarm value must not ring
    i_alarm_en = 2'b10;
    set_time(0, 1, 4);
    i_pos = 2'd0; i_inc = 1; cycle();
    cycle(); cycle();
    chk("edit_noring", 32'(o_ring), 32'd0);
    chk("edit_sec", 32'(o_sec), 32'd5);

`ifdef HMS_SNOOZE_EN
    set_time(0, 0, 0);
    ring_up();
    i_snooze = 1; cycle();
    chk("snz_ring", 32'(o_ring), 32'd0);
    chk("snz_ch", 32'(o_ring_ch), 32'b10);
    tick_gap(); tick_gap();
    chk("snz_2", 32'(o_ring), 32'd0);
    i_tick = 1; cycle();
    chk("snz_back", 32'(o_ring), 32'd1);
    chk("snz_back_ch", 32'(o_ring_ch), 32'b10);
    i_snooze = 1; cycle();
    i_alarm_ack = 1; cycle();
    chk("snz_ack_ch", 32'(o_ring_ch), 32'd0);
    tick_gap();
    chk("snz_ack_ring", 32'(o_ring), 32'd0);
`endif

    // Randomized traffic against the model
    for (int rnd = 0; rnd < 4; rnd++) begin
      i_alarm_en = 2'b11;
      t2 = (m_t + 6) % DAY;
      set_alarm(rnd % NUM, t2 / 3600, t2 / 60 % 60, t2 % 60);
      for (int c = 0; c < 300; c++) begin
        r = int'($urandom_range(0, 99));
        if (r < 85) i_mode = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
        else if (r < 93) i_mode = 2'b01;
        else i_mode = 2'b10;
        i_pos       = 2'($urandom_range(0, 3));
        i_alarm_sel = AW'($urandom_range(0, NUM - 1));
        i_inc       = ($urandom_range(0, 3) == 0);
        i_tick      = ($urandom_range(0, 2) == 0);
        i_alarm_ack = ($urandom_range(0, 31) == 0);
        if ($urandom_range(0, 63) == 0) i_alarm_en = NUM'($urandom);
`ifdef HMS_SNOOZE_EN
        i_snooze    = ($urandom_range(0, 19) == 0);
`endif
        cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
